// File: rtl/mul_div_seq_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer:
// funct3 operation codes, ALU control codes and sequencer states.
package mul_div_seq_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

endpackage

// File: rtl/mul_div_seq_alu.sv
// Core integer ALU: add/sub/and/or/slt with N, Z, C, V flags.
// C is the adder carry-out, so for subtraction C=1 means "no borrow".
module mul_div_seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       alu_control_i,
   output logic [WIDTH-1:0] y_o,
   output logic             n_o,
   output logic             z_o,
   output logic             c_o,
   output logic             v_o
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             arith;

   assign b_eff = alu_control_i[0] ? ~b_i : b_i;
   assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alu_control_i[0]};
   assign arith = ~alu_control_i[1];

   always_comb begin
      y_o = '0;
      unique case (alu_control_i)
         3'b000, 3'b001: y_o = sum[WIDTH-1:0];
         3'b010:         y_o = a_i & b_i;
         3'b011:         y_o = a_i | b_i;
         3'b101:         y_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v_o};
         default:        y_o = '0;
      endcase
   end

   assign n_o = y_o[WIDTH-1];
   assign z_o = (y_o == '0);
   assign c_o = arith & sum[WIDTH];
   assign v_o = arith & (a_i[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/mul_div_seq.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) sequencer.
// All add/subtract work goes through one shared ALU instance.
module mul_div_seq
   import mul_div_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [2:0]          op_q;
   logic [2*XLEN-1:0]   p_q;
   logic [XLEN-1:0]     m_q;
   logic                neg_q;
   logic [XLEN-1:0]     result_q;

   logic                a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]     a_abs, b_abs;
   logic                div_zero, div_ovf, special, accept;
   logic [XLEN-1:0]     special_res;

   logic                calc, is_div_q;
   logic [XLEN-1:0]     div_shift, alu_a, alu_b, alu_y;
   logic [2:0]          alu_ctrl;
   logic                alu_c, div_take;
   logic [2:0]          alu_nzv_unused;
   logic [2*XLEN-1:0]   p_step, prod_fix;
   logic [XLEN-1:0]     div_sel, fix_res;

   // Operand decode at accept: MULHSU treats only rs1 as signed.
   assign a_signed = (op == OP_MUL) | (op == OP_MULH) | (op == OP_MULHSU) |
                     (op == OP_DIV) | (op == OP_REM);
   assign b_signed = (op == OP_MUL) | (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
   assign a_neg    = a_signed & a[XLEN-1];
   assign b_neg    = b_signed & b[XLEN-1];
   assign a_abs    = a_neg ? -a : a;
   assign b_abs    = b_neg ? -b : b;

   assign div_zero    = op[2] & (b == '0);
   assign div_ovf     = ((op == OP_DIV) | (op == OP_REM)) &
                        (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
   assign special     = div_zero | div_ovf;
   // Overflow: DIV returns a (the most negative value), REM returns 0.
   assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
   assign accept      = (state_q == IDLE) & start & ~kill;

   assign calc      = (state_q == CALC);
   assign is_div_q  = op_q[2];
   assign div_shift = p_q[2*XLEN-2:XLEN-1];
   assign alu_a     = calc ? (is_div_q ? div_shift : p_q[2*XLEN-1:XLEN]) : '0;
   assign alu_b     = calc ? m_q : '0;
   assign alu_ctrl  = (calc & is_div_q) ? ALU_SUB : ALU_ADD;

   mul_div_seq_alu #(.WIDTH(XLEN)) u_alu (
      .a_i           (alu_a),
      .b_i           (alu_b),
      .alu_control_i (alu_ctrl),
      .y_o           (alu_y),
      .n_o           (alu_nzv_unused[2]),
      .z_o           (alu_nzv_unused[1]),
      .c_o           (alu_c),
      .v_o           (alu_nzv_unused[0])
   );

   // Divide: a set shifted-out remainder MSB means the trial can never borrow.
   assign div_take = p_q[2*XLEN-1] | alu_c;
   assign p_step   = is_div_q ?
                     {(div_take ? alu_y : div_shift), p_q[XLEN-2:0], div_take} :
                     (p_q[0] ? {alu_c, alu_y, p_q[XLEN-1:1]} : {1'b0, p_q[2*XLEN-1:1]});

   assign prod_fix = neg_q ? -p_q : p_q;
   assign div_sel  = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
   assign fix_res  = is_div_q ? (neg_q ? -div_sel : div_sel) :
                     ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = special ? DONE : CALC;
         CALC: if (kill) state_d = IDLE; else if (cnt_q == '0) state_d = FIX;
         FIX:  state_d = kill ? IDLE : DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == CALC) | (state_q == FIX);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         op_q     <= '0;
         p_q      <= '0;
         m_q      <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         op_q  <= op;
         cnt_q <= CNT_W'(XLEN-1);
         neg_q <= (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
         p_q   <= {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
         m_q   <= op[2] ? b_abs : a_abs;
         if (special) result_q <= special_res;
      end else if (calc & ~kill) begin
         p_q   <= p_step;
         cnt_q <= cnt_q - 1'b1;
      end else if ((state_q == FIX) & ~kill) begin
         result_q <= fix_res;
      end
   end

   assign result = result_q;

endmodule
